// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared definitions for the run-length detector.
//   - run_state_e   : detector state encoding (IDLE, RUN, HIT)
//   - DEF_*         : default parameter values
//   - min_run_legal : elaboration-time range check for MIN_RUN
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2
    } run_state_e;

    localparam int DEF_MIN_RUN = 2;
    localparam int DEF_CNT_W   = 4;
    localparam int DEF_HIT_W   = 8;

    // MIN_RUN must be reachable by a CNT_W-bit saturating counter.
    function automatic bit min_run_legal(input int min_run, input int cnt_w);
        return (min_run >= 1) && (min_run <= (1 << cnt_w) - 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-low reset
//   clr   - synchronous clear (below reset in priority)
//   inc   - count enable
//   cnt   - registered count
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/seq_run_detect.sv
// seq_run_detect: counts consecutive qualified 1s on din and flags when the
// run reaches MIN_RUN. Level or one-cycle-pulse indication, run-length
// readout, count of detected runs, optional longest-run tracker.
// Optional feature macro: SEQ_RUN_MAXRUN_EN (builds the max_run register;
// when undefined max_run is tied to 0).
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous active-low reset
//   din        - serial data bit
//   valid      - qualifies din; when low all state holds
//   clear      - synchronous soft clear of run state, hit_cnt, max_run
//   pulse_mode - 0 = level detect, 1 = one-cycle pulse per run
//   detect     - registered detection flag
//   run_len    - current consecutive-1 count, saturating
//   hit_cnt    - number of runs that reached MIN_RUN, wrapping
//   max_run    - longest run since reset/clear
//
// state | meaning
// ------+----------------------------------------
// IDLE  | run_len = 0
// RUN   | 0 < run_len < MIN_RUN
// HIT   | run_len >= MIN_RUN, run detected
module seq_run_detect
    import seq_det_pkg::*;
#(
    parameter int MIN_RUN = DEF_MIN_RUN,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int HIT_W   = DEF_HIT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             valid,
    input  logic             clear,
    input  logic             pulse_mode,
    output logic             detect,
    output logic [CNT_W-1:0] run_len,
    output logic [HIT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] max_run
);

    if (!min_run_legal(MIN_RUN, CNT_W)) begin : g_bad_min_run
        $error("seq_run_detect: MIN_RUN outside 1 .. 2^CNT_W-1");
    end

    localparam logic [CNT_W-1:0] MIN_RUN_V = CNT_W'(MIN_RUN);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    run_state_e       state;
    run_state_e       state_d;
    logic             hit_entry;
    logic [CNT_W-1:0] run_next;

    // A sampled 0 restarts the run; a sampled 1 extends it.
    sat_counter #(.W(CNT_W)) u_run_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear | (valid & ~din)),
        .inc   (valid & din),
        .cnt   (run_len)
    );

    always_comb begin
        run_next  = (run_len == CNT_MAX) ? run_len : run_len + CNT_W'(1);
        state_d   = state;
        hit_entry = 1'b0;
        if (valid) begin
            if (din) begin
                // One compare covers both IDLE->HIT (MIN_RUN=1) and RUN->HIT.
                if ((state != HIT) && (run_next == MIN_RUN_V)) begin
                    state_d   = HIT;
                    hit_entry = 1'b1;
                end else if (state == IDLE) begin
                    state_d = RUN;
                end
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            detect  <= 1'b0;
            hit_cnt <= '0;
        end else if (clear) begin
            state   <= IDLE;
            detect  <= 1'b0;
            hit_cnt <= '0;
        end else if (valid) begin
            state  <= state_d;
            detect <= pulse_mode ? hit_entry : (state_d == HIT);
            if (hit_entry) begin
                hit_cnt <= hit_cnt + HIT_W'(1);
            end
        end else if (pulse_mode) begin
            // A pulse never survives an idle (valid=0) cycle.
            detect <= 1'b0;
        end
    end

`ifdef SEQ_RUN_MAXRUN_EN
    logic [CNT_W-1:0] max_run_q;

    // Compared against the post-update run length so max_run is current
    // on the same edge as run_len.
    always_ff @(posedge clk) begin
        if (!reset) begin
            max_run_q <= '0;
        end else if (clear) begin
            max_run_q <= '0;
        end else if (valid && din && (run_next > max_run_q)) begin
            max_run_q <= run_next;
        end
    end

    assign max_run = max_run_q;
`else
    assign max_run = '0;
`endif

endmodule

// File: tb/tb_seq_run_detect.sv
// tb_seq_run_detect: self-checking bench for seq_run_detect. Four instances
// share one stimulus stream: A (MIN_RUN=2), B (MIN_RUN=3), C (CNT_W=2),
// D (HIT_W=2). Expected outputs are queued as stimulus is driven and
// compared just after the following rising edge.
module tb_seq_run_detect;

`ifdef SEQ_RUN_MAXRUN_EN
    localparam bit MR_EN = 1'b1;
`else
    localparam bit MR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, din, valid, clear, pulse_mode;

    logic       a_det, b_det, c_det, d_det;
    logic [3:0] a_rl, b_rl, d_rl, a_mr, b_mr, d_mr;
    logic [1:0] c_rl, c_mr, d_hc;
    logic [7:0] a_hc, b_hc, c_hc;

    always #5 clk = ~clk;

    seq_run_detect #(.MIN_RUN(2), .CNT_W(4), .HIT_W(8)) u_a (
        .clk(clk), .reset(reset), .din(din), .valid(valid), .clear(clear),
        .pulse_mode(pulse_mode), .detect(a_det), .run_len(a_rl),
        .hit_cnt(a_hc), .max_run(a_mr));
    seq_run_detect #(.MIN_RUN(3), .CNT_W(4), .HIT_W(8)) u_b (
        .clk(clk), .reset(reset), .din(din), .valid(valid), .clear(clear),
        .pulse_mode(pulse_mode), .detect(b_det), .run_len(b_rl),
        .hit_cnt(b_hc), .max_run(b_mr));
    seq_run_detect #(.MIN_RUN(2), .CNT_W(2), .HIT_W(8)) u_c (
        .clk(clk), .reset(reset), .din(din), .valid(valid), .clear(clear),
        .pulse_mode(pulse_mode), .detect(c_det), .run_len(c_rl),
        .hit_cnt(c_hc), .max_run(c_mr));
    seq_run_detect #(.MIN_RUN(2), .CNT_W(4), .HIT_W(2)) u_d (
        .clk(clk), .reset(reset), .din(din), .valid(valid), .clear(clear),
        .pulse_mode(pulse_mode), .detect(d_det), .run_len(d_rl),
        .hit_cnt(d_hc), .max_run(d_mr));

    // Packed view: {detect, run_len[3:0], hit_cnt[7:0], max_run[3:0]}
    typedef struct {
        int          dut;
        logic [16:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [16:0] obs(input int d);
        case (d)
            0:       return {a_det, a_rl, a_hc, a_mr};
            1:       return {b_det, b_rl, b_hc, b_mr};
            2:       return {c_det, 2'b00, c_rl, c_hc, 2'b00, c_mr};
            3:       return {d_det, d_rl, 6'b0, d_hc, d_mr};
            default: return '0;
        endcase
    endfunction

    function automatic exp_t mk(input int d, input bit det, input int rl,
                                input int hc, input int mr, input string tag);
        exp_t e;
        e.dut = d;
        e.val = {det, 4'(rl), 8'(hc), (MR_EN ? 4'(mr) : 4'd0)};
        e.tag = tag;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit d, input bit v, input bit c);
        din   = d;
        valid = v;
        clear = c;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(0, 0, 0);
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        exp_t        e;
        logic [16:0] o;
        bit          dv[3] = '{1, 1, 0};
        reset      = 1'b0;
        pulse_mode = 1'b0;
        drive(1, 1, 0);
        for (int i = 0; i < 2; i++) begin
            sb.push_back(mk(0, 0, 0, 0, 0, "reset_hold"));
            tick();
            while (sb.size() != 0) begin
                e = sb.pop_front(); o = obs(e.dut); checks++;
                if (o !== e.val) begin
                    failures++;
                    $display("FAIL %s dut%0d got=%h expected=%h", e.tag, e.dut, o, e.val);
                end
            end
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(dv[i], 1, 0);
            case (i)
                0: sb.push_back(mk(0, 0, 1, 0, 1, "first_run_c1"));
                1: sb.push_back(mk(0, 1, 2, 1, 2, "first_run_c2"));
                default: sb.push_back(mk(0, 0, 0, 1, 2, "first_run_c3"));
            endcase
            tick();
            while (sb.size() != 0) begin
                e = sb.pop_front(); o = obs(e.dut); checks++;
                if (o !== e.val) begin
                    failures++;
                    $display("FAIL %s dut%0d got=%h expected=%h", e.tag, e.dut, o, e.val);
                end
            end
        end
    endtask

    task automatic test_pulse();
        exp_t        e;
        logic [16:0] o;
        bit vv[6]  = '{1, 1, 1, 0, 1, 1};
        int a_d[6] = '{0, 1, 0, 0, 0, 0};
        int a_r[6] = '{1, 2, 3, 3, 4, 5};
        int a_h[6] = '{0, 1, 1, 1, 1, 1};
        int b_d[6] = '{0, 0, 1, 0, 0, 0};
        int b_h[6] = '{0, 0, 1, 1, 1, 1};
        do_reset();
        pulse_mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1, vv[i], 0);
            sb.push_back(mk(0, a_d[i] != 0, a_r[i], a_h[i], a_r[i], "pulse_min2"));
            sb.push_back(mk(1, b_d[i] != 0, a_r[i], b_h[i], a_r[i], "pulse_min3"));
            tick();
            while (sb.size() != 0) begin
                e = sb.pop_front(); o = obs(e.dut); checks++;
                if (o !== e.val) begin
                    failures++;
                    $display("FAIL %s dut%0d cyc%0d got=%h expected=%h", e.tag, e.dut, i, o, e.val);
                end
            end
        end
        pulse_mode = 1'b0;
    endtask

    task automatic test_valid_gating();
        exp_t        e;
        logic [16:0] o;
        bit vv[5]  = '{1, 0, 0, 1, 0};
        int r[5]   = '{1, 1, 1, 2, 2};
        int dt[5]  = '{0, 0, 0, 1, 1};
        do_reset();
        pulse_mode = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1, vv[i], 0);
            sb.push_back(mk(0, dt[i] != 0, r[i], dt[i], r[i], "valid_gate"));
            tick();
            while (sb.size() != 0) begin
                e = sb.pop_front(); o = obs(e.dut); checks++;
                if (o !== e.val) begin
                    failures++;
                    $display("FAIL %s dut%0d cyc%0d got=%h expected=%h", e.tag, e.dut, i, o, e.val);
                end
            end
        end
    endtask

    task automatic test_saturation();
        exp_t        e;
        logic [16:0] o;
        int c_r[6] = '{1, 2, 3, 3, 3, 3};
        do_reset();
        pulse_mode = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 0);
            sb.push_back(mk(2, i > 0, c_r[i], (i > 0) ? 1 : 0, c_r[i], "sat_cntw2"));
            sb.push_back(mk(0, i > 0, i + 1, (i > 0) ? 1 : 0, i + 1, "nosat_cntw4"));
            tick();
            while (sb.size() != 0) begin
                e = sb.pop_front(); o = obs(e.dut); checks++;
                if (o !== e.val) begin
                    failures++;
                    $display("FAIL %s dut%0d cyc%0d got=%h expected=%h", e.tag, e.dut, i, o, e.val);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [16:0] o;
        do_reset();
        pulse_mode = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            for (int c = 0; c < 3; c++) begin
                drive(c != 2, 1, 0);
                case (c)
                    0: begin
                        sb.push_back(mk(3, 0, 1, (k - 1) % 4, (k == 1) ? 1 : 2, "b2b_hitw2"));
                        sb.push_back(mk(0, 0, 1, k - 1, (k == 1) ? 1 : 2, "b2b_hitw8"));
                    end
                    1: begin
                        sb.push_back(mk(3, 1, 2, k % 4, 2, "b2b_hitw2"));
                        sb.push_back(mk(0, 1, 2, k, 2, "b2b_hitw8"));
                    end
                    default: begin
                        sb.push_back(mk(3, 0, 0, k % 4, 2, "b2b_hitw2"));
                        sb.push_back(mk(0, 0, 0, k, 2, "b2b_hitw8"));
                    end
                endcase
                tick();
                while (sb.size() != 0) begin
                    e = sb.pop_front(); o = obs(e.dut); checks++;
                    if (o !== e.val) begin
                        failures++;
                        $display("FAIL %s dut%0d run%0d cyc%0d got=%h expected=%h",
                                 e.tag, e.dut, k, c, o, e.val);
                    end
                end
            end
        end
    endtask

    task automatic test_clear();
        exp_t        e;
        logic [16:0] o;
        bit cv[5]  = '{0, 0, 1, 0, 0};
        int dt[5]  = '{0, 1, 0, 0, 1};
        int r[5]   = '{1, 2, 0, 1, 2};
        do_reset();
        pulse_mode = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, cv[i]);
            sb.push_back(mk(0, dt[i] != 0, r[i], dt[i], r[i], "clear_vs_valid"));
            tick();
            while (sb.size() != 0) begin
                e = sb.pop_front(); o = obs(e.dut); checks++;
                if (o !== e.val) begin
                    failures++;
                    $display("FAIL %s dut%0d cyc%0d got=%h expected=%h", e.tag, e.dut, i, o, e.val);
                end
            end
        end
        clear = 1'b0;
    endtask

    task automatic test_maxrun();
        exp_t        e;
        logic [16:0] o;
        bit dv[7]  = '{1, 1, 1, 0, 1, 1, 0};
        int dt[7]  = '{0, 1, 1, 0, 0, 1, 0};
        int r[7]   = '{1, 2, 3, 0, 1, 2, 0};
        int h[7]   = '{0, 1, 1, 1, 1, 2, 2};
        int m[7]   = '{1, 2, 3, 3, 3, 3, 3};
        do_reset();
        pulse_mode = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(dv[i], 1, 0);
            sb.push_back(mk(0, dt[i] != 0, r[i], h[i], m[i], "max_run"));
            tick();
            while (sb.size() != 0) begin
                e = sb.pop_front(); o = obs(e.dut); checks++;
                if (o !== e.val) begin
                    failures++;
                    $display("FAIL %s dut%0d cyc%0d got=%h expected=%h", e.tag, e.dut, i, o, e.val);
                end
            end
        end
    endtask

    task automatic test_mode_switch_and_reset();
        exp_t        e;
        logic [16:0] o;
        bit pm[5]  = '{0, 0, 1, 0, 0};
        bit rs[5]  = '{1, 1, 1, 1, 0};
        int dt[5]  = '{0, 1, 0, 1, 0};
        int r[5]   = '{1, 2, 3, 4, 0};
        int h[5]   = '{0, 1, 1, 1, 0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            pulse_mode = pm[i];
            reset      = rs[i];
            drive(1, 1, 0);
            sb.push_back(mk(0, dt[i] != 0, r[i], h[i], r[i], "mode_sw_reset"));
            tick();
            while (sb.size() != 0) begin
                e = sb.pop_front(); o = obs(e.dut); checks++;
                if (o !== e.val) begin
                    failures++;
                    $display("FAIL %s dut%0d cyc%0d got=%h expected=%h", e.tag, e.dut, i, o, e.val);
                end
            end
        end
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; din = 1'b0; valid = 1'b0; clear = 1'b0; pulse_mode = 1'b0;
        test_reset();
        test_pulse();
        test_valid_gating();
        test_saturation();
        test_back_to_back();
        test_clear();
        test_maxrun();
        test_mode_switch_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_run_detect.md
# seq_run_detect

Parametrised run-length detector for a serial bit stream. Counts consecutive 1s on a qualified input and flags when the current run reaches a programmable minimum length. Supports level or single-pulse indication, a run-length readout and a count of detected runs. Sits after any serial front end in the FSM-logic family and generalises the fixed "more than one 1" sequence detector.

## Interface
Parameters:
- MIN_RUN, 2, run length (in valid 1-bits) at which a run counts as detected; legal range 1 .. 2^CNT_W-1
- CNT_W, 4, width of the run-length counter and `run_len`/`max_run` outputs
- HIT_W, 8, width of the detected-run counter `hit_cnt`

Ports:
- clk, input, 1, rising-edge clock; the block's only clock
- reset, input, 1, synchronous, active-low reset; sampled on rising `clk`
- din, input, 1, serial data bit
- valid, input, 1, qualifies `din`; when 0 all state holds
- clear, input, 1, synchronous soft clear of run state, `hit_cnt` and `max_run`
- pulse_mode, input, 1, 0 = level detect, 1 = one-cycle pulse per run
- detect, output, 1, registered detection flag
- run_len, output, CNT_W, current consecutive-1 count, saturating
- hit_cnt, output, HIT_W, number of runs that reached MIN_RUN, wraps modulo 2^HIT_W
- max_run, output, CNT_W, longest run since reset/clear (see Configuration)

## Operation
- States: IDLE (run_len = 0), RUN (0 < run_len < MIN_RUN), HIT (run_len >= MIN_RUN).
- On an edge with valid=1, din=1: run_len increments, saturating at 2^CNT_W-1. IDLE→RUN, or IDLE→HIT when MIN_RUN=1. RUN→HIT when the new count equals MIN_RUN. HIT stays in HIT.
- On an edge with valid=1, din=0: run_len ← 0, any state → IDLE.
- valid=0: state, run_len, detect, hit_cnt and max_run hold. In pulse mode, `detect` drops to 0.
- Level mode: detect = 1 exactly while the state is HIT.
- Pulse mode: detect = 1 only on the cycle following entry into HIT. Otherwise 0.
- hit_cnt increments once per entry into HIT, independent of pulse_mode.
- Priority: reset > clear > valid. clear returns the state to IDLE, and zeroes run_len, detect, hit_cnt and max_run.
- pulse_mode may change at any time. It takes effect on the next edge and does not alter state.

## Timing
- Reset values: state IDLE, detect 0, run_len 0, hit_cnt 0, max_run 0.
- All outputs are registered. Latency is one edge: the edge that samples the MIN_RUN-th 1 also sets detect, visible right after that edge.
- The edge that samples a 0 clears detect. There is no hold-over.
- Back-to-back runs separated by a single 0 are detected independently. Runs do not overlap across a 0.
- Reset asserted mid-run discards the run without incrementing hit_cnt.
- Saturation: at run_len = 2^CNT_W-1, further 1s keep run_len and state unchanged.

## Configuration
- SEQ_RUN_MAXRUN_EN defined: max_run register tracks max(max_run, run_len) after every update. Cleared by reset/clear.
- SEQ_RUN_MAXRUN_EN undefined: no max_run register is built, and the `max_run` port is tied to 0.

## Structure
- Shared package seq_det_pkg holds:
  - the state enum (IDLE, RUN, HIT)
  - default widths
  - an elaboration-time check function for the MIN_RUN range
- One sub-module, sat_counter, is natural: a CNT_W saturating up-counter with synchronous clear, used for run_len.
- FSM, hit counter and max tracker stay in the top.

## Test plan
- Reset and defaults (MIN_RUN=2): reset=0 for 2 edges with din=1 → detect=0, run_len=0, hit_cnt=0. Release reset; din=1,1,0 with valid=1 → detect 0,1,0; run_len 1,2,0; hit_cnt=1.
- Pulse mode, MIN_RUN=3: pulse_mode=1, din=1 ×5 → detect high only after the 3rd 1; hit_cnt=1; run_len=5.
- Valid gating: din=1, valid pattern 1,0,0,1 → run_len 1,1,1,2; detect rises only after the 4th edge.
- Saturation and wrap:
  - CNT_W=2: din=1 ×6 → run_len sticks at 3.
  - HIT_W=2: five runs of "1,1,0" → hit_cnt reads 1,2,3,0,1.
- Clear vs. valid: clear=1 on the same edge as valid=1, din=1 during HIT → state IDLE, run_len=0, detect=0, hit_cnt=0.
- Macro: with SEQ_RUN_MAXRUN_EN, runs of 3 then 2 → max_run=3. Without it → max_run=0 throughout.
